p405s_timer_pit_ctl: RTL and testbench

//  Sequencing controller for the PIT down-counter datapath and its reload register.
//  - Decides each cycle whether the PIT count is written, decremented, reloaded or cleared.
//  - Orders mtSPR writes against timer-tic decrements and detects the 1->0 expiry.
//  - Holds the PIT status bit (TSR[PIS]) and raises the PIT interrupt request.
//  - Sits between PCL/TCR/TSR control and the PIT count/reload registers in the timer unit.

---
 rtl/p405s_timer_pit_ctl_if.sv | 31 +++
 rtl/p405s_timer_pit_ctl.sv | 169 ++++++++++++++++
 tb/tb_p405s_timer_pit_ctl.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/p405s_timer_pit_ctl_if.sv
// ============================================================================
// Module  : p405s_timer_pit_ctl_if
// Brief   : mtSPR write bus from PCL into the PIT sequencing controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface p405s_timer_pit_ctl_if #(
    parameter int PIT_W = 32
);
    logic             PCL_mtSPR;
    logic             PCL_sprHold;
    logic             pitDcd;
    logic [PIT_W-1:0] EXE_sprDataBus;

    modport master (
        output PCL_mtSPR,
        output PCL_sprHold,
        output pitDcd,
        output EXE_sprDataBus
    );

    modport slave (
        input  PCL_mtSPR,
        input  PCL_sprHold,
        input  pitDcd,
        input  EXE_sprDataBus
    );
endinterface

`default_nettype wire

// File: rtl/p405s_timer_pit_ctl.sv
// ============================================================================
// Module  : p405s_timer_pit_ctl
// Brief   : PIT down-counter sequencing, expiry detect and TSR[PIS] status.
//           Optional tic prescaler built in with `define P405S_PIT_PRESCALE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module p405s_timer_pit_ctl #(
    parameter int PIT_W      = 32,
    parameter int PRESCALE_W = 8
) (
    input  wire                  CB,
    input  wire                  resetNEG,
    p405s_timer_pit_ctl_if.slave sprBus,
    input  wire                  tcrARenable,
    input  wire                  tcrPIEenable,
    input  wire                  tsrPisClr,
    input  wire                  freezeTimersNEG,
    input  wire                  timerTic,
    input  wire [PRESCALE_W-1:0] prescaleDiv,
    input  wire                  LSSD_coreTestEn,
    input  wire [PIT_W-1:0]      pitL2,
    output logic                 pitCntEn,
    output logic [1:0]           pitMuxSel,
    output logic                 pitReloadEn,
    output logic                 hwSetPitStatus,
    output logic                 pitStatus,
    output logic                 pitIntReq,
    output logic [1:0]           pitState
);

    localparam logic [1:0] c_SEL_DEC    = 2'b00;
    localparam logic [1:0] c_SEL_ZERO   = 2'b01;
    localparam logic [1:0] c_SEL_RELOAD = 2'b10;
    localparam logic [1:0] c_SEL_SPR    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_EXPIRE = 2'b10
    } pitState_t;

    pitState_t        r_state;
    pitState_t        w_next;
    logic             r_ticDly;
    logic             r_hwSet;
    logic             r_pitStatus;
    logic             r_areAtExp;
    logic             w_wrAcc;
    logic             w_ticEdge;
    logic             w_ticEvt;
    logic             w_expiry;
    logic             w_pitZero;
    logic             w_pitOne;
    logic             w_dataZero;
    logic             w_cntEn;
    logic             w_reloadEn;
    logic [1:0]       w_sel;

    assign w_wrAcc    = sprBus.PCL_mtSPR & sprBus.pitDcd & ~sprBus.PCL_sprHold;
    assign w_ticEdge  = timerTic & ~r_ticDly & freezeTimersNEG;
    assign w_pitZero  = (pitL2 == '0);
    assign w_pitOne   = (pitL2 == PIT_W'(1));
    assign w_dataZero = (sprBus.EXE_sprDataBus == '0);

`ifdef P405S_PIT_PRESCALE_EN
    // Passes one tic edge in every (prescaleDiv+1); restarts on each PIT write.
    logic [PRESCALE_W-1:0] r_preCnt;
    logic                  w_preHit;

    assign w_preHit = (r_preCnt == prescaleDiv);
    assign w_ticEvt = w_ticEdge & w_preHit;

    always_ff @(posedge CB or negedge resetNEG) begin
        if (!resetNEG) begin
            r_preCnt <= '0;
        end else if (!LSSD_coreTestEn) begin
            if (w_wrAcc) begin
                r_preCnt <= '0;
            end else if (w_ticEdge) begin
                r_preCnt <= w_preHit ? '0 : r_preCnt + PRESCALE_W'(1);
            end
        end
    end
`else
    logic w_unusedPrescale;
    assign w_unusedPrescale = ^prescaleDiv;
    assign w_ticEvt         = w_ticEdge;
`endif

    always_comb begin
        w_cntEn    = 1'b0;
        w_reloadEn = 1'b0;
        w_sel      = c_SEL_DEC;
        w_next     = r_state;
        w_expiry   = 1'b0;
        if (w_wrAcc) begin
            // A write always wins; a tic in the same cycle is simply lost.
            w_cntEn    = 1'b1;
            w_reloadEn = 1'b1;
            w_sel      = c_SEL_SPR;
            w_next     = w_dataZero ? ST_IDLE : ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_pitZero) begin
                        w_next = ST_IDLE;
                    end else if (w_ticEvt) begin
                        w_cntEn = 1'b1;
                        if (w_pitOne) begin
                            w_sel    = tcrARenable ? c_SEL_RELOAD : c_SEL_ZERO;
                            w_next   = ST_EXPIRE;
                            w_expiry = 1'b1;
                        end
                    end
                end
                ST_EXPIRE: begin
                    w_next = (r_areAtExp && !w_pitZero) ? ST_RUN : ST_IDLE;
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
        if (LSSD_coreTestEn) begin
            w_cntEn    = 1'b0;
            w_reloadEn = 1'b0;
            w_next     = r_state;
            w_expiry   = 1'b0;
        end
    end

    always_ff @(posedge CB or negedge resetNEG) begin
        if (!resetNEG) begin
            r_state     <= ST_IDLE;
            r_ticDly    <= 1'b0;
            r_hwSet     <= 1'b0;
            r_pitStatus <= 1'b0;
            r_areAtExp  <= 1'b0;
        end else begin
            // Edge detector keeps tracking while frozen so unfreeze cannot fire a tic.
            r_ticDly <= timerTic;
            r_state  <= w_next;
            if (!LSSD_coreTestEn) begin
                r_hwSet <= w_expiry;
                if (w_expiry) begin
                    r_areAtExp <= tcrARenable;
                end
                if (r_hwSet) begin
                    r_pitStatus <= 1'b1;
                end else if (tsrPisClr) begin
                    r_pitStatus <= 1'b0;
                end
            end
        end
    end

    assign pitCntEn       = w_cntEn;
    assign pitReloadEn    = w_reloadEn;
    assign pitMuxSel      = w_sel;
    assign hwSetPitStatus = r_hwSet;
    assign pitStatus      = r_pitStatus;
    assign pitIntReq      = r_pitStatus & tcrPIEenable;
    assign pitState       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_p405s_timer_pit_ctl.sv
// ============================================================================
// Module  : tb_p405s_timer_pit_ctl
// Brief   : Directed self-checking bench for the PIT sequencing controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_p405s_timer_pit_ctl;

    logic        CB = 1'b0;
    logic        resetNEG;
    logic        tcrARenable;
    logic        tcrPIEenable;
    logic        tsrPisClr;
    logic        freezeTimersNEG;
    logic        timerTic;
    logic [7:0]  prescaleDiv;
    logic        LSSD_coreTestEn;
    logic [31:0] pitL2;
    logic [31:0] reloadReg;
    logic        pitCntEn;
    logic [1:0]  pitMuxSel;
    logic        pitReloadEn;
    logic        hwSetPitStatus;
    logic        pitStatus;
    logic        pitIntReq;
    logic [1:0]  pitState;

    int checks = 0;
    int errors = 0;
    int pulseCnt = 0;
    int p0;

    p405s_timer_pit_ctl_if #(.PIT_W(32)) sprIf ();

    p405s_timer_pit_ctl #(.PIT_W(32), .PRESCALE_W(8)) dut (
        .CB              (CB),
        .resetNEG        (resetNEG),
        .sprBus          (sprIf),
        .tcrARenable     (tcrARenable),
        .tcrPIEenable    (tcrPIEenable),
        .tsrPisClr       (tsrPisClr),
        .freezeTimersNEG (freezeTimersNEG),
        .timerTic        (timerTic),
        .prescaleDiv     (prescaleDiv),
        .LSSD_coreTestEn (LSSD_coreTestEn),
        .pitL2           (pitL2),
        .pitCntEn        (pitCntEn),
        .pitMuxSel       (pitMuxSel),
        .pitReloadEn     (pitReloadEn),
        .hwSetPitStatus  (hwSetPitStatus),
        .pitStatus       (pitStatus),
        .pitIntReq       (pitIntReq),
        .pitState        (pitState)
    );

    always #5 CB = ~CB;

    // PIT count and reload registers that this controller steers
    always @(posedge CB or negedge resetNEG) begin
        if (!resetNEG) begin
            pitL2     <= '0;
            reloadReg <= '0;
        end else begin
            if (pitReloadEn) reloadReg <= sprIf.EXE_sprDataBus;
            if (pitCntEn) begin
                case (pitMuxSel)
                    2'b00:   pitL2 <= pitL2 - 32'd1;
                    2'b01:   pitL2 <= '0;
                    2'b10:   pitL2 <= reloadReg;
                    default: pitL2 <= sprIf.EXE_sprDataBus;
                endcase
            end
        end
    end

    always @(negedge CB) if (hwSetPitStatus) pulseCnt++;

    task automatic drive_tic();
        @(negedge CB); timerTic = 1'b1;
        @(negedge CB); timerTic = 1'b0;
    endtask

    task automatic drive_mtspr(input logic [31:0] d);
        @(negedge CB);
        sprIf.PCL_mtSPR = 1'b1; sprIf.pitDcd = 1'b1; sprIf.EXE_sprDataBus = d;
        @(negedge CB);
        sprIf.PCL_mtSPR = 1'b0; sprIf.pitDcd = 1'b0; sprIf.EXE_sprDataBus = '0;
    endtask

    task automatic clear_pis();
        @(negedge CB); tsrPisClr = 1'b1;
        @(negedge CB); tsrPisClr = 1'b0;
    endtask

    task automatic test_reset();
        resetNEG = 1'b0; tcrARenable = 1'b0; tcrPIEenable = 1'b1; tsrPisClr = 1'b0;
        freezeTimersNEG = 1'b1; timerTic = 1'b0; prescaleDiv = 8'd0; LSSD_coreTestEn = 1'b0;
        sprIf.PCL_mtSPR = 1'b0; sprIf.PCL_sprHold = 1'b0; sprIf.pitDcd = 1'b0;
        sprIf.EXE_sprDataBus = '0;
        repeat (2) @(negedge CB);
        checks++;
        if ({pitState, pitStatus, hwSetPitStatus, pitIntReq} !== 5'b0) begin
            errors++;
            $display("FAIL reset_regs: got state=%0d pis=%0b hw=%0b irq=%0b, expected all 0",
                     pitState, pitStatus, hwSetPitStatus, pitIntReq);
        end
        checks++;
        if ({pitCntEn, pitReloadEn, pitMuxSel} !== 4'b0) begin
            errors++;
            $display("FAIL reset_enables: got cntEn=%0b reloadEn=%0b sel=%0d, expected 0 0 0",
                     pitCntEn, pitReloadEn, pitMuxSel);
        end
        resetNEG = 1'b1;
    endtask

    task automatic test_oneshot();
        tcrARenable = 1'b0;
        p0 = pulseCnt;
        drive_mtspr(32'd3);
        checks++;
        if (pitL2 !== 32'd3 || pitState !== 2'b01) begin
            errors++;
            $display("FAIL oneshot_load: got count=%0d state=%0d, expected 3 1", pitL2, pitState);
        end
        drive_tic();
        checks++;
        if (pitL2 !== 32'd2) begin errors++; $display("FAIL oneshot_dec1: got %0d expected 2", pitL2); end
        drive_tic();
        checks++;
        if (pitL2 !== 32'd1) begin errors++; $display("FAIL oneshot_dec2: got %0d expected 1", pitL2); end
        drive_tic();
        checks++;
        if (pitL2 !== 32'd0 || pitState !== 2'b10 || hwSetPitStatus !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_expire: got count=%0d state=%0d hw=%0b, expected 0 2 1",
                     pitL2, pitState, hwSetPitStatus);
        end
        @(negedge CB);
        checks++;
        if (pitState !== 2'b00 || pitStatus !== 1'b1 || pulseCnt - p0 !== 1) begin
            errors++;
            $display("FAIL oneshot_end: got state=%0d pis=%0b pulses=%0d, expected 0 1 1",
                     pitState, pitStatus, pulseCnt - p0);
        end
    endtask

    task automatic test_autoreload();
        tcrARenable = 1'b1;
        clear_pis();
        checks++;
        if (pitStatus !== 1'b0) begin errors++; $display("FAIL pis_clear: got %0b expected 0", pitStatus); end
        p0 = pulseCnt;
        drive_mtspr(32'd2);
        drive_tic();
        checks++;
        if (pitL2 !== 32'd1) begin errors++; $display("FAIL are_dec1: got %0d expected 1", pitL2); end
        drive_tic();
        checks++;
        if (pitL2 !== 32'd2 || pitState !== 2'b10) begin
            errors++;
            $display("FAIL are_reload1: got count=%0d state=%0d, expected 2 2", pitL2, pitState);
        end
        drive_tic();
        checks++;
        if (pitL2 !== 32'd1 || pitState !== 2'b01) begin
            errors++;
            $display("FAIL are_dec2: got count=%0d state=%0d, expected 1 1", pitL2, pitState);
        end
        drive_tic();
        @(negedge CB);
        checks++;
        if (pitL2 !== 32'd2 || pitState !== 2'b01 || pitStatus !== 1'b1 || pulseCnt - p0 !== 2) begin
            errors++;
            $display("FAIL are_end: got count=%0d state=%0d pis=%0b pulses=%0d, expected 2 1 1 2",
                     pitL2, pitState, pitStatus, pulseCnt - p0);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge CB);
        timerTic = 1'b1;
        sprIf.PCL_mtSPR = 1'b1; sprIf.pitDcd = 1'b1; sprIf.EXE_sprDataBus = 32'd5;
        #1;
        checks++;
        if (pitMuxSel !== 2'b11 || pitCntEn !== 1'b1 || pitReloadEn !== 1'b1) begin
            errors++;
            $display("FAIL collide_sel: got sel=%0d cntEn=%0b reloadEn=%0b, expected 3 1 1",
                     pitMuxSel, pitCntEn, pitReloadEn);
        end
        @(negedge CB);
        timerTic = 1'b0;
        sprIf.PCL_mtSPR = 1'b0; sprIf.pitDcd = 1'b0; sprIf.EXE_sprDataBus = '0;
        @(negedge CB);
        checks++;
        if (pitL2 !== 32'd5 || pitState !== 2'b01) begin
            errors++;
            $display("FAIL collide_count: got count=%0d state=%0d, expected 5 1", pitL2, pitState);
        end
    endtask

    task automatic test_freeze();
        freezeTimersNEG = 1'b0;
        repeat (10) drive_tic();
        checks++;
        if (pitL2 !== 32'd5 || pitState !== 2'b01) begin
            errors++;
            $display("FAIL freeze_hold: got count=%0d state=%0d, expected 5 1", pitL2, pitState);
        end
        drive_mtspr(32'd9);
        checks++;
        if (pitL2 !== 32'd9) begin errors++; $display("FAIL freeze_write: got %0d expected 9", pitL2); end
        @(negedge CB); timerTic = 1'b1;
        repeat (2) @(negedge CB);
        freezeTimersNEG = 1'b1;
        repeat (2) @(negedge CB);
        checks++;
        if (pitL2 !== 32'd9) begin errors++; $display("FAIL unfreeze_tic: got %0d expected 9", pitL2); end
        timerTic = 1'b0;
        drive_tic();
        checks++;
        if (pitL2 !== 32'd8) begin errors++; $display("FAIL resume_dec: got %0d expected 8", pitL2); end
    endtask

    task automatic test_lssd();
        @(negedge CB);
        LSSD_coreTestEn = 1'b1; timerTic = 1'b1;
        sprIf.PCL_mtSPR = 1'b1; sprIf.pitDcd = 1'b1; sprIf.EXE_sprDataBus = 32'd7;
        #1;
        checks++;
        if (pitCntEn !== 1'b0 || pitReloadEn !== 1'b0) begin
            errors++;
            $display("FAIL lssd_enables: got cntEn=%0b reloadEn=%0b, expected 0 0", pitCntEn, pitReloadEn);
        end
        @(negedge CB);
        sprIf.PCL_mtSPR = 1'b0; sprIf.pitDcd = 1'b0; sprIf.EXE_sprDataBus = '0;
        timerTic = 1'b0; LSSD_coreTestEn = 1'b0;
        checks++;
        if (pitL2 !== 32'd8 || pitState !== 2'b01) begin
            errors++;
            $display("FAIL lssd_hold: got count=%0d state=%0d, expected 8 1", pitL2, pitState);
        end
    endtask

    task automatic test_set_clear();
        tcrARenable = 1'b0; tcrPIEenable = 1'b1;
        clear_pis();
        checks++;
        if (pitIntReq !== 1'b0) begin errors++; $display("FAIL irq_low: got %0b expected 0", pitIntReq); end
        drive_mtspr(32'd1);
        drive_tic();
        tsrPisClr = 1'b1;
        @(negedge CB);
        tsrPisClr = 1'b0;
        checks++;
        if (pitStatus !== 1'b1 || pitIntReq !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: got pis=%0b irq=%0b, expected 1 1", pitStatus, pitIntReq);
        end
        tcrPIEenable = 1'b0;
        #1;
        checks++;
        if (pitIntReq !== 1'b0) begin errors++; $display("FAIL irq_pie_off: got %0b expected 0", pitIntReq); end
    endtask

    task automatic test_no_wrap();
        drive_mtspr(32'd0);
        checks++;
        if (pitL2 !== 32'd0 || pitState !== 2'b00) begin
            errors++;
            $display("FAIL zero_write: got count=%0d state=%0d, expected 0 0", pitL2, pitState);
        end
        @(negedge CB); timerTic = 1'b1;
        #1;
        checks++;
        if (pitCntEn !== 1'b0) begin errors++; $display("FAIL idle_tic_en: got %0b expected 0", pitCntEn); end
        @(negedge CB); timerTic = 1'b0;
        checks++;
        if (pitL2 !== 32'd0) begin errors++; $display("FAIL no_wrap: got %0d expected 0", pitL2); end
    endtask

    task automatic test_prescale();
        logic [31:0] expCnt;
        logic [1:0]  expState;
`ifdef P405S_PIT_PRESCALE_EN
        expCnt = 32'd2; expState = 2'b01;
`else
        expCnt = 32'd0; expState = 2'b00;
`endif
        tcrARenable = 1'b0; prescaleDiv = 8'd3;
        drive_mtspr(32'd4);
        repeat (8) drive_tic();
        @(negedge CB);
        checks++;
        if (pitL2 !== expCnt || pitState !== expState) begin
            errors++;
            $display("FAIL prescale: got count=%0d state=%0d, expected %0d %0d",
                     pitL2, pitState, expCnt, expState);
        end
    endtask

    task automatic test_reset_mid();
        prescaleDiv = 8'd0;
        drive_mtspr(32'd1);
        drive_tic();
        checks++;
        if (pitState !== 2'b10) begin errors++; $display("FAIL mid_pre: got state=%0d expected 2", pitState); end
        #1 resetNEG = 1'b0;
        #1;
        checks++;
        if (pitState !== 2'b00 || hwSetPitStatus !== 1'b0 || pitStatus !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got state=%0d hw=%0b pis=%0b, expected 0 0 0",
                     pitState, hwSetPitStatus, pitStatus);
        end
        @(negedge CB); resetNEG = 1'b1;
        repeat (2) @(negedge CB);
        checks++;
        if (pitStatus !== 1'b0 || pitState !== 2'b00) begin
            errors++;
            $display("FAIL mid_lost: got pis=%0b state=%0d, expected 0 0", pitStatus, pitState);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_autoreload();
        test_back_to_back();
        test_freeze();
        test_lssd();
        test_set_clear();
        test_no_wrap();
        test_prescale();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
